// File: rtl/scs8hd_lpflow_lsbuf_pwr_seq_pkg.sv
// Shared definitions for the lsbuf power sequencer.
// Contents:
//   state_t    3-bit FSM state encodings. The encodings are fixed because
//              they appear on the debug state port.
//   clog2      ceiling log2, used to size counters from cycle parameters.
//   max3       maximum of three integers.
package scs8hd_lpflow_lsbuf_pwr_seq_pkg;

    typedef enum logic [2:0] {
        ST_ON      = 3'd0,
        ST_ISO_SET = 3'd1,
        ST_SW_OFF  = 3'd2,
        ST_OFF     = 3'd3,
        ST_SW_ON   = 3'd4,
        ST_RAMP    = 3'd5,
        ST_ISO_REL = 3'd6,
        ST_ERR     = 3'd7
    } state_t;

    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/scs8hd_lpflow_lsbuf_pwr_seq_if.sv
// PMU-facing handshake of the lsbuf power sequencer.
// Signals:
//   req      PMU -> seq  level, 1 = domain off requested
//   err_clr  PMU -> seq  single-cycle pulse, clears the fault state
//   ack      seq -> PMU  1 = domain off/safe
//   err      seq -> PMU  sticky supply-fault flag
//   state    seq -> PMU  current FSM state code (debug)
// Modports: master = PMU side, slave = sequencer side.
interface scs8hd_lpflow_lsbuf_pwr_seq_if;
    logic       req;
    logic       err_clr;
    logic       ack;
    logic       err;
    logic [2:0] state;

    modport master (output req, output err_clr, input ack, input err, input state);
    modport slave  (input req, input err_clr, output ack, output err, output state);
endinterface

// File: rtl/scs8hd_lpflow_lsbuf_pwr_seq_sync2.sv
// Two-flop synchroniser for asynchronous rail-monitor flags.
// Ports:
//   clk    in  destination clock
//   reset  in  synchronous, active-high; both flops clear to 0
//   d      in  asynchronous input
//   q      out synchronised output, 2 cycles latency
module scs8hd_lpflow_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/scs8hd_lpflow_lsbuf_pwr_seq.sv
// Power-down/up sequencer for a switchable vpwrin domain feeding vpwr through
// lsbuf_lh_hl isowell cells. Orders the isolation clamp and the header switch
// against the PMU req/ack handshake, waits on the synchronised supply-good
// flag, applies settle/ramp delays and traps supply faults. Always-on domain.
// Ports:
//   clk          in   always-on clock
//   reset        in   synchronous, active-high
//   pmu          if   req/err_clr in, ack/err/state out (slave modport)
//   vpwrin_good  in   asynchronous supply-good from the vpwrin rail monitor
//   iso_en       out  1 = lsbuf outputs clamped
//   pwr_sw_en    out  1 = header switch closed
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ON       | domain powered, isolation released
// ISO_SET  | clamp applied, waiting for it to settle before opening switch
// SW_OFF   | switch open, waiting for supply-good to drop
// OFF      | domain off and safe, waiting for req=0
// SW_ON    | switch closed, waiting for supply-good to rise
// RAMP     | supply good, letting the rail settle
// ISO_REL  | clamp released, waiting for it to settle before dropping ack
// ERR      | supply fault trapped, switch open, waiting for err_clr
module scs8hd_lpflow_lsbuf_pwr_seq
    import scs8hd_lpflow_lsbuf_pwr_seq_pkg::*;
#(
    parameter int ISO_SETTLE_CYC = 4,
    parameter int RAMP_CYC       = 16,
    parameter int TIMEOUT_CYC    = 256
) (
    input  logic                           clk,
    input  logic                           reset,
    scs8hd_lpflow_lsbuf_pwr_seq_if.slave   pmu,
    input  logic                           vpwrin_good,
    output logic                           iso_en,
    output logic                           pwr_sw_en
);
    localparam int CNT_W = clog2(max3(ISO_SETTLE_CYC, RAMP_CYC, TIMEOUT_CYC) + 1);

    localparam logic [CNT_W-1:0] ISO_LAST  = CNT_W'(ISO_SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] RAMP_LAST = CNT_W'(RAMP_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt;
    logic             good_s;
    logic             iso_d;
    logic             sw_d;
    logic             ack_d;
    logic             ack_q;
    logic             err_q;

    scs8hd_lpflow_sync2 u_good_sync (
        .clk   (clk),
        .reset (reset),
        .d     (vpwrin_good),
        .q     (good_s)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ON: begin
                // a supply loss outranks a pending power-down request
                if (!good_s)              state_d = ST_ERR;
                else if (pmu.req)         state_d = ST_ISO_SET;
            end
            ST_ISO_SET: begin
                if (cnt == ISO_LAST)      state_d = ST_SW_OFF;
            end
            ST_SW_OFF: begin
                if (!good_s)              state_d = ST_OFF;
                else if (cnt == TMO_LAST) state_d = ST_ERR;
            end
            ST_OFF: begin
                if (!pmu.req)             state_d = ST_SW_ON;
            end
            ST_SW_ON: begin
                if (good_s)               state_d = ST_RAMP;
                else if (cnt == TMO_LAST) state_d = ST_ERR;
            end
            ST_RAMP: begin
                if (!good_s)              state_d = ST_ERR;
                else if (cnt == RAMP_LAST) state_d = ST_ISO_REL;
            end
            ST_ISO_REL: begin
                if (!good_s)              state_d = ST_ERR;
                else if (cnt == ISO_LAST) state_d = ST_ON;
            end
            ST_ERR: begin
                if (pmu.err_clr)          state_d = ST_OFF;
            end
            default:                      state_d = ST_ERR;
        endcase
    end

    // Outputs decode from the next state so they move on the same edge as it.
    always_comb begin
        iso_d = 1'b1;
        sw_d  = 1'b0;
        ack_d = 1'b1;
        case (state_d)
            ST_ON:      begin iso_d = 1'b0; sw_d = 1'b1; ack_d = 1'b0; end
            ST_ISO_SET: begin iso_d = 1'b1; sw_d = 1'b1; ack_d = 1'b0; end
            ST_SW_OFF:  begin iso_d = 1'b1; sw_d = 1'b0; ack_d = 1'b0; end
            ST_OFF:     begin iso_d = 1'b1; sw_d = 1'b0; ack_d = 1'b1; end
            ST_SW_ON:   begin iso_d = 1'b1; sw_d = 1'b1; ack_d = 1'b1; end
            ST_RAMP:    begin iso_d = 1'b1; sw_d = 1'b1; ack_d = 1'b1; end
            ST_ISO_REL: begin iso_d = 1'b0; sw_d = 1'b1; ack_d = 1'b1; end
            ST_ERR:     begin iso_d = 1'b1; sw_d = 1'b0; ack_d = 1'b1; end
            default:    begin iso_d = 1'b1; sw_d = 1'b0; ack_d = 1'b1; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_SW_ON;
            cnt       <= '0;
            iso_en    <= 1'b1;
            pwr_sw_en <= 1'b1;
            ack_q     <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            iso_en    <= iso_d;
            pwr_sw_en <= sw_d;
            ack_q     <= ack_d;
            // ERR is only left through err_clr, so the flag tracks ERR residency
            err_q     <= (state_d == ST_ERR);
            if (state_d != state_q)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
        end
    end

    assign pmu.ack   = ack_q;
    assign pmu.err   = err_q;
    assign pmu.state = state_q;

endmodule

// File: tb/tb_scs8hd_lpflow_lsbuf_pwr_seq.sv
module tb_scs8hd_lpflow_lsbuf_pwr_seq;

    localparam logic [2:0] S_ON      = 3'd0;
    localparam logic [2:0] S_ISO_SET = 3'd1;
    localparam logic [2:0] S_SW_OFF  = 3'd2;
    localparam logic [2:0] S_OFF     = 3'd3;
    localparam logic [2:0] S_SW_ON   = 3'd4;
    localparam logic [2:0] S_RAMP    = 3'd5;
    localparam logic [2:0] S_ISO_REL = 3'd6;
    localparam logic [2:0] S_ERR     = 3'd7;

    typedef struct {
        logic       rst;
        logic       req;
        logic       clr;
        logic       gf_en;
        logic       gf_val;
        int         cyc;
        logic [6:0] outs;   // {state, iso_en, pwr_sw_en, ack, err}
    } vec_t;

    typedef struct {
        int         id;
        logic [6:0] outs;
    } exp_t;

    logic clk;
    logic reset;
    logic vpwrin_good;
    logic iso_en;
    logic pwr_sw_en;
    logic gf_en;
    logic gf_val;
    logic good_follow;

    int n_checks;
    int n_pass;
    int cyc;
    int idx_b;
    int idx_c;

    vec_t vecs[$];
    exp_t exp_q[$];

    scs8hd_lpflow_lsbuf_pwr_seq_if pmu_bus ();

    scs8hd_lpflow_lsbuf_pwr_seq dut (
        .clk         (clk),
        .reset       (reset),
        .pmu         (pmu_bus),
        .vpwrin_good (vpwrin_good),
        .iso_en      (iso_en),
        .pwr_sw_en   (pwr_sw_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rail model: supply-good follows the switch one half cycle later unless forced.
    initial good_follow = 1'b1;
    always @(negedge clk) good_follow = pwr_sw_en;
    assign vpwrin_good = gf_en ? gf_val : good_follow;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic add(input logic rst, input logic req, input logic clr,
                       input logic gfe, input logic gfv, input int c,
                       input logic [2:0] st, input logic iso, input logic sw,
                       input logic ack, input logic err);
        vec_t v;
        v.rst = rst; v.req = req; v.clr = clr; v.gf_en = gfe; v.gf_val = gfv;
        v.cyc = c; v.outs = {st, iso, sw, ack, err};
        vecs.push_back(v);
    endtask

    function automatic logic [6:0] outs_now();
        return {pmu_bus.state, iso_en, pwr_sw_en, pmu_bus.ack, pmu_bus.err};
    endfunction

    task automatic apply(input int id);
        exp_t e;
        exp_t got;
        reset           = vecs[id].rst;
        pmu_bus.req     = vecs[id].req;
        pmu_bus.err_clr = vecs[id].clr;
        gf_en           = vecs[id].gf_en;
        gf_val          = vecs[id].gf_val;
        e.id   = id;
        e.outs = vecs[id].outs;
        exp_q.push_back(e);
        repeat (vecs[id].cyc) @(posedge clk);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            got = exp_q.pop_front();
            check($sformatf("vec%0d", got.id), 32'(outs_now()), 32'(got.outs));
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset = 1'b1; pmu_bus.req = 1'b0; pmu_bus.err_clr = 1'b0;
        gf_en = 1'b0; gf_val = 1'b1;

        // reset state
        add(1,0,0,0,1, 2, S_SW_ON,   1,1,1,0);
        idx_b = vecs.size();
        // ON -> OFF
        add(0,1,0,0,1, 1, S_ISO_SET, 1,1,0,0);
        add(0,1,0,0,1, 3, S_ISO_SET, 1,1,0,0);
        add(0,1,0,0,1, 1, S_SW_OFF,  1,0,0,0);
        add(0,1,0,0,1, 2, S_SW_OFF,  1,0,0,0);
        add(0,1,0,0,1, 1, S_OFF,     1,0,1,0);
        add(0,1,0,0,1, 5, S_OFF,     1,0,1,0);
        // OFF -> ON
        add(0,0,0,0,1, 1, S_SW_ON,   1,1,1,0);
        add(0,0,0,0,1, 3, S_RAMP,    1,1,1,0);
        add(0,0,0,0,1, 15, S_RAMP,   1,1,1,0);
        add(0,0,0,0,1, 1, S_ISO_REL, 0,1,1,0);
        add(0,0,0,0,1, 3, S_ISO_REL, 0,1,1,0);
        add(0,0,0,0,1, 1, S_ON,      0,1,0,0);
        // one-cycle supply glitch in ON; fault wins over a simultaneous req
        add(0,0,0,1,0, 1, S_ON,      0,1,0,0);
        add(0,0,0,0,1, 1, S_ON,      0,1,0,0);
        add(0,1,0,0,1, 1, S_ERR,     1,0,1,1);
        add(0,0,0,0,1, 3, S_ERR,     1,0,1,1);
        add(0,1,0,0,1, 2, S_ERR,     1,0,1,1);
        add(0,1,1,0,1, 1, S_OFF,     1,0,1,0);
        add(0,1,0,0,1, 3, S_OFF,     1,0,1,0);
        add(0,0,0,0,1, 24, S_ON,     0,1,0,0);
        // req toggling during ISO_SET is ignored
        add(0,1,0,0,1, 1, S_ISO_SET, 1,1,0,0);
        add(0,0,0,0,1, 2, S_ISO_SET, 1,1,0,0);
        add(0,1,0,0,1, 1, S_ISO_SET, 1,1,0,0);
        add(0,0,0,0,1, 1, S_SW_OFF,  1,0,0,0);
        add(0,0,0,0,1, 3, S_OFF,     1,0,1,0);
        add(0,0,0,0,1, 1, S_SW_ON,   1,1,1,0);
        add(0,0,0,0,1, 22, S_ISO_REL,0,1,1,0);
        add(0,0,0,0,1, 1, S_ON,      0,1,0,0);
        // reset in RAMP
        add(0,1,0,0,1, 8, S_OFF,     1,0,1,0);
        add(0,0,0,0,1, 5, S_RAMP,    1,1,1,0);
        add(1,0,0,0,1, 1, S_SW_ON,   1,1,1,0);
        idx_c = vecs.size();
        // after the SW_ON timeout: clear the fault, then power up again
        add(0,0,1,1,0, 1, S_OFF,     1,0,1,0);
        add(0,0,0,0,1, 24, S_ON,     0,1,0,0);

        apply(0);

        // power-up from reset: count edges until ack falls
        reset = 1'b0;
        cyc = 0;
        while (cyc < 100) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (pmu_bus.ack == 1'b0) break;
        end
        check("ack_fall_cycles", 32'(cyc), 32'd23);
        check("powerup_outs", 32'(outs_now()), 32'({S_ON, 1'b1 ^ 1'b1, 1'b1, 1'b0, 1'b0}));

        for (int i = idx_b; i < idx_c; i++) apply(i);

        // SW_ON timeout with supply-good held low
        gf_en = 1'b1; gf_val = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc = 0;
        while (cyc < 400) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (pmu_bus.err == 1'b1) break;
        end
        check("timeout_cycles", 32'(cyc), 32'd256);
        check("timeout_outs", 32'(outs_now()), 32'({S_ERR, 1'b1, 1'b0, 1'b1, 1'b1}));

        for (int i = idx_c; i < vecs.size(); i++) apply(i);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
